// File: rtl/flash_rom_loader.sv
// flash_rom_loader: boot-time copy of a 2**A byte image from SPI flash
// (single READ 0x03 at FLASH_BASE) into a RAM-resident ROM through a
// simple address/data/write-enable port. SPI mode 0, MSB first.
module flash_rom_loader #(
    parameter int          A          = 14,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          DIV        = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         spi_cs_n,
    output logic         spi_sck,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [A-1:0] ram_a,
    output logic [7:0]   ram_d,
    output logic         ram_we
);

    localparam int          CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   cmd_sr_q, cmd_sr_d;
    logic [4:0]    cmd_bit_q, cmd_bit_d;
    logic [A-1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [6:0]    rx_q, rx_d;
    logic [A-1:0]  ram_a_q, ram_a_d;
    logic [7:0]    ram_d_q, ram_d_d;
    logic          ram_we_q, ram_we_d;

    // Next-state logic: FSM, half-period divider, shift registers and write strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cmd_sr_d   = cmd_sr_q;
        cmd_bit_d  = cmd_bit_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        rx_d       = rx_q;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        ram_we_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CMD;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    sck_d      = 1'b0;
                    mosi_d     = CMD_WORD[31];
                    cmd_sr_d   = CMD_WORD << 1;
                    cmd_bit_d  = 5'd0;
                    byte_idx_d = '0;
                    bit_idx_d  = 3'd0;
                    cnt_d      = '0;
                end
            end
            S_CMD, S_DATA: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: sample MISO; the 8th data bit completes a byte.
                        sck_d = 1'b1;
                        rx_d  = {rx_q[5:0], spi_miso};
                        if (state_q == S_DATA && bit_idx_q == 3'd7) begin
                            ram_we_d = 1'b1;
                            ram_a_d  = byte_idx_q;
                            ram_d_d  = {rx_q, spi_miso};
                        end
                    end else begin
                        // Falling SCK: present the next command bit or advance the data counters.
                        sck_d = 1'b0;
                        if (state_q == S_CMD) begin
                            if (cmd_bit_q == 5'd31) begin
                                state_d = S_DATA;
                                mosi_d  = 1'b0;
                            end else begin
                                mosi_d    = cmd_sr_q[31];
                                cmd_sr_d  = cmd_sr_q << 1;
                                cmd_bit_d = cmd_bit_q + 5'd1;
                            end
                        end else if (bit_idx_q == 3'd7 && (&byte_idx_q)) begin
                            state_d = S_FIN;
                            cs_n_d  = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                byte_idx_d = byte_idx_q + A'(1);
                            end
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transfer and returns every output to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_sr_q   <= '0;
            cmd_bit_q  <= 5'd0;
            byte_idx_q <= '0;
            bit_idx_q  <= 3'd0;
            rx_q       <= '0;
            ram_a_q    <= '0;
            ram_d_q    <= 8'd0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cmd_sr_q   <= cmd_sr_d;
            cmd_bit_q  <= cmd_bit_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            rx_q       <= rx_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            ram_we_q   <= ram_we_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign ram_a    = ram_a_q;
    assign ram_d    = ram_d_q;
    assign ram_we   = ram_we_q;

endmodule
